// File: rtl/pc_reg.sv
// Program counter register: holds the fetch address and advances it by PC_INC or loads a branch target.
// Latency: one cycle from is_branch/newPC to PC; PC_plus and misaligned are combinational from PC.
// Backpressure: none without PC_STALL_EN; with PC_STALL_EN, stall holds PC and overrides is_branch.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset      - asynchronous, active-low; forces PC to RESET_VECTOR immediately
//   is_branch  - level-sensitive; load newPC at each rising edge it is high
//   newPC      - 32-bit branch/jump target, loaded unmodified (misaligned targets included)
//   stall      - only when PC_STALL_EN is defined; hold PC at the edge
//   PC         - registered program counter
//   PC_plus    - PC + PC_INC, modulo 2^32, no carry out
//   misaligned - high when PC[1:0] is non-zero
//
// Optional feature macro: PC_STALL_EN (adds the stall port).

module pc_reg #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_INC       = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_branch,
    input  logic [31:0] newPC,
`ifdef PC_STALL_EN
    input  logic        stall,
`endif
    output logic [31:0] PC,
    output logic [31:0] PC_plus,
    output logic        misaligned
);

    logic [31:0] next_pc;

    // Wrap-around is intentional: the 32-bit result simply drops the carry.
    assign PC_plus    = PC + PC_INC;

    // Derived only from the registered PC so a pending target never leaks into these outputs.
    assign misaligned = |PC[1:0];

    always_comb begin
        next_pc = is_branch ? newPC : PC_plus;
`ifdef PC_STALL_EN
        // Stall wins over a branch: the branch request is dropped, not deferred.
        if (stall) begin
            next_pc = PC;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC <= RESET_VECTOR;
        end else begin
            PC <= next_pc;
        end
    end

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed cases plus randomized branch/stall/reset traffic.
// Expected PC comes from a reference model updated once per rising edge from the input rules.
// Outputs are sampled 1 ns after each rising edge, or mid-cycle for asynchronous reset checks.

module tb_pc_reg;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] INC = 32'd4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        is_branch = 1'b0;
    logic [31:0] newPC     = 32'd0;
`ifdef PC_STALL_EN
    logic        stall     = 1'b0;
`endif
    logic [31:0] PC;
    logic [31:0] PC_plus;
    logic        misaligned;

    logic [31:0] exp_pc = RV;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    pc_reg #(
        .RESET_VECTOR (RV),
        .PC_INC       (INC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .is_branch  (is_branch),
        .newPC      (newPC),
`ifdef PC_STALL_EN
        .stall      (stall),
`endif
        .PC         (PC),
        .PC_plus    (PC_plus),
        .misaligned (misaligned)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp_plus;
        logic [31:0] exp_mis;
        exp_plus = exp_pc + INC;
        exp_mis  = (exp_pc % 4 != 0) ? 32'd1 : 32'd0;
        check_val({tag, ".pc"},   PC, exp_pc);
        check_val({tag, ".plus"}, PC_plus, exp_plus);
        check_val({tag, ".mis"},  {31'd0, misaligned}, exp_mis);
    endtask

    // Reference model: applies the update rules at a rising edge, then checks 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        if (!reset) begin
            exp_pc = RV;
        end
`ifdef PC_STALL_EN
        else if (stall) begin
            exp_pc = exp_pc;
        end
`endif
        else if (is_branch) begin
            exp_pc = newPC;
        end else begin
            exp_pc = exp_pc + INC;
        end
        #1;
        check_outputs(tag);
    endtask

    // One-edge branch followed by one increment edge, with literal expectations.
    task automatic br_case(input string tag, input logic [31:0] tgt, input logic [31:0] nxt,
                           input logic mis_tgt, input logic mis_nxt);
        is_branch = 1'b1;
        newPC     = tgt;
        step(tag);
        check_val({tag, ".tgt"}, PC, tgt);
        check_val({tag, ".tgt_mis"}, {31'd0, misaligned}, {31'd0, mis_tgt});
        is_branch = 1'b0;
        newPC     = $urandom;
        step({tag, "_n"});
        check_val({tag, ".nxt"}, PC, nxt);
        check_val({tag, ".nxt_mis"}, {31'd0, misaligned}, {31'd0, mis_nxt});
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #1 reset = 1'b0;
        #1 exp_pc = RV;
        check_outputs("rst_async");

        // Reset dominates a branch request across edges.
        is_branch = 1'b1;
        newPC     = 32'h1234_5678;
        step("rst_hold0");
        step("rst_hold1");

        // Mid-cycle release, then ten plain increments.
        #3 reset  = 1'b1;
        is_branch = 1'b0;
        for (int i = 0; i < 10; i++) step("inc");
        check_val("inc10_pc", PC, 32'h0000_0028);
        check_val("inc10_plus", PC_plus, 32'h0000_002C);

        br_case("br_aaaa", 32'hAAAA_AAAA, 32'hAAAA_AAAE, 1'b1, 1'b1);
        br_case("br_5555", 32'h5555_5555, 32'h5555_5559, 1'b1, 1'b1);
        br_case("br_wrap", 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0);

        // Asynchronous reset between edges while PC is 5555_5600.
        is_branch = 1'b1;
        newPC     = 32'h5555_5600;
        step("pre_rst");
        check_val("pre_rst_lit", PC, 32'h5555_5600);
        #2 reset  = 1'b0;
        exp_pc    = RV;
        #1 check_outputs("rst_mid");
        newPC     = $urandom;
        #50 check_outputs("rst_50ns");
        is_branch = 1'b0;
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 3; i++) step("resume");
        check_val("resume_lit", PC, 32'h0000_000C);

        // Level-sensitive branch held for three edges with a fresh target each time.
        is_branch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            newPC = $urandom;
            step("lvl");
        end
        is_branch = 1'b0;
        step("lvl_end");

`ifdef PC_STALL_EN
        is_branch = 1'b1;
        newPC     = 32'h0000_0010;
        step("st_pre");
        stall     = 1'b1;
        newPC     = 32'h0000_0080;
        for (int i = 0; i < 3; i++) step("st_hold");
        check_val("st_hold_lit", PC, 32'h0000_0010);
        stall     = 1'b0;
        step("st_rel");
        check_val("st_rel_lit", PC, 32'h0000_0080);
        is_branch = 1'b0;
        step("st_inc");
`endif

        // Randomized traffic, with occasional mid-cycle reset pulses.
        for (int i = 0; i < 300; i++) begin
            is_branch = ($urandom_range(0, 3) == 0);
            newPC     = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
`ifdef PC_STALL_EN
            stall     = ($urandom_range(0, 4) == 0);
`endif
            step("rnd");
            if ($urandom_range(0, 29) == 0) begin
                #2 reset = 1'b0;
                exp_pc   = RV;
                #1 check_outputs("rnd_rst");
                #1 reset = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_reg.md
PC_REG -- requirements
Module: pc_reg

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded by reset.
REQ-002 Parameter PC_INC, default 4: sequential increment added each cycle.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 Port is_branch  input  1  high = load newPC at next rising edge instead of incrementing.
REQ-006 Port newPC  input  32  branch/jump target address.
REQ-007 Port PC  output  32  registered current program counter.
REQ-008 Port PC_plus  output  32  combinational PC + PC_INC, modulo 2^32.
REQ-009 Port misaligned  output  1  combinational; high when PC[1:0] != 2'b00.
REQ-010 Port stall  input  1  present only with PC_STALL_EN; high = hold PC.

Function
REQ-011 Rising clk edge, reset high, is_branch low: PC SHALL become PC + PC_INC.
REQ-012 Rising clk edge, reset high, is_branch high: PC SHALL become newPC, all 32 bits loaded unmodified (misaligned targets included).
REQ-013 Latency SHALL be one cycle: a branch sampled at edge N is visible on PC after edge N; increments resume from newPC at edge N+1.
REQ-014 is_branch is level-sensitive; held high for k edges, PC SHALL load newPC at each of those k edges.
REQ-015 Arithmetic SHALL be unsigned 32-bit with wrap-around; 32'hFFFF_FFFC + 4 = 32'h0000_0000, no carry output.
REQ-016 PC_plus and misaligned SHALL be purely combinational from PC, never from newPC.
REQ-017 No other state exists; block has no handshake and accepts a new branch every cycle.

Reset
REQ-018 reset low SHALL force PC to RESET_VECTOR immediately, without waiting for clk.
REQ-019 While reset is low, PC SHALL hold RESET_VECTOR regardless of is_branch, newPC, stall.
REQ-020 Reset SHALL dominate a simultaneous branch or stall.
REQ-021 After reset goes high, the first rising edge SHALL perform a normal update (increment or branch).
REQ-022 Reset values: PC = RESET_VECTOR, PC_plus = RESET_VECTOR + PC_INC, misaligned = |RESET_VECTOR[1:0].

Configuration
REQ-023 Macro PC_STALL_EN defined: stall port exists; at a rising edge with stall high, PC SHALL hold its value and is_branch SHALL be ignored (stall beats branch); reset still dominates stall.
REQ-024 Macro PC_STALL_EN undefined: no stall port; PC SHALL update every rising edge per REQ-011/REQ-012.

Verification
REQ-025 Reset low 5 ns mid-cycle, then high; 10 edges, is_branch=0 -> PC goes 0 to 32'h0000_0028 in steps of 4; PC_plus = 32'h0000_002C.
REQ-026 newPC=32'hAAAA_AAAA, is_branch high for one edge -> PC=32'hAAAA_AAAA, misaligned=1; next edge PC=32'hAAAA_AAAE.
REQ-027 newPC=32'h5555_5555, one-edge branch -> PC=32'h5555_5555, then 32'h5555_5559, misaligned=1.
REQ-028 Branch to 32'hFFFF_FFFC -> next edge PC=32'h0000_0000, misaligned=0.
REQ-029 reset low between clock edges while PC=32'h5555_5600 -> PC=32'h0000_0000 before the next edge; held 50 ns, then increments resume from 0.
REQ-030 With PC_STALL_EN: PC=32'h10, stall=1 and is_branch=1 (newPC=32'h80) for 3 edges -> PC stays 32'h10; stall=0 -> next edge PC=32'h80 if is_branch still high, else 32'h14.
